uart_rx: RTL and testbench

Serial-to-parallel UART receiver for 8N1 framing: 8 data bits, LSB first, one start bit, one stop bit, no parity. It pairs with `uart_tx` at the far end of the link and feeds received bytes to the core-side bus logic. The receiver synchronises the asynchronous line, rejects start-bit glitches, samples each bit at mid-bit, and flags framing errors and break conditions.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_CNT_W     = 9;
    localparam int unsigned UART_IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error and break handling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [UART_CNT_W-1:0] LastCnt = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_CNT_W-1:0] HalfCnt = UART_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [UART_IDX_W-1:0] LastIdx = UART_IDX_W'(UART_DATA_BITS - 1);

    logic                      r_Rx;
    rx_state_t                 state_q, state_d;
    logic [UART_CNT_W-1:0]     cnt_q, cnt_d;
    logic [UART_IDX_W-1:0]     idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      dv_q, dv_d;
    logic                      fe_q, fe_d;
    logic                      active_q, active_d;

    uart_sync #(
        .ResetVal(1'b1)
    ) u_rx_sync (
        .clk_i(i_Clock),
        .rst_i(i_Reset),
        .d_i  (i_Rx_Serial),
        .q_o  (r_Rx)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!r_Rx) state_d = START;
            START:   if (cnt_q == HalfCnt) state_d = r_Rx ? IDLE : DATA;
            DATA:    if (cnt_q == LastCnt && idx_q == LastIdx) state_d = STOP;
            STOP:    if (cnt_q == LastCnt) state_d = r_Rx ? IDLE : BREAK;
            // A line held low after a bad stop bit must return high before re-arming.
            BREAK:   if (r_Rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        fe_d     = 1'b0;
        active_d = (state_q == START) || (state_q == DATA) || (state_q == STOP);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                cnt_d = (cnt_q == HalfCnt) ? '0 : cnt_q + 1'b1;
            end
            DATA: begin
                if (cnt_q == LastCnt) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = r_Rx;
                    idx_d          = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (r_Rx) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                idx_d = '0;
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
    end

    assign o_Rx_DV     = dv_q;
    assign o_Frame_Err = fe_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 and 87 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst16, rst87;
    logic       rx16, rx87;
    logic       dv16, dv87, act16, act87, fe16, fe87;
    logic [7:0] byte16, byte87;

    int         cyc = 0;
    int         t0 = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         dv_cyc16[$];
    logic [7:0] dv_byte16[$];
    int         dv_cyc87[$];
    logic [7:0] dv_byte87[$];
    int         fe_cnt16 = 0;
    int         fe_cyc16 = 0;
    int         fe_cnt87 = 0;
    int         overlap = 0;

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .i_Clock    (clk),
        .i_Reset    (rst16),
        .i_Rx_Serial(rx16),
        .o_Rx_DV    (dv16),
        .o_Rx_Byte  (byte16),
        .o_Rx_Active(act16),
        .o_Frame_Err(fe16)
    );

    uart_rx #(.CLKS_PER_BIT(87)) dut87 (
        .i_Clock    (clk),
        .i_Reset    (rst87),
        .i_Rx_Serial(rx87),
        .o_Rx_DV    (dv87),
        .o_Rx_Byte  (byte87),
        .o_Rx_Active(act87),
        .o_Frame_Err(fe87)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv16) begin
            dv_cyc16.push_back(cyc);
            dv_byte16.push_back(byte16);
        end
        if (fe16) begin
            fe_cnt16++;
            fe_cyc16 = cyc;
        end
        if (dv87) begin
            dv_cyc87.push_back(cyc);
            dv_byte87.push_back(byte87);
        end
        if (fe87) fe_cnt87++;
        if ((dv16 && fe16) || (dv87 && fe87)) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx16 = v;
        else rx87 = v;
    endtask

    // Called at a negedge; edge 0 is the next posedge. Returns 10n cycles later, at a negedge.
    task automatic send_frame(input int which, input int n, input logic [7:0] b, input logic stop);
        set_line(which, 1'b0);
        t0 = cyc + 1;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            repeat (n) @(negedge clk);
        end
        set_line(which, stop);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t_first;
        logic [7:0] v;

        rst16 = 1'b1;
        rst87 = 1'b1;
        rx16  = 1'b1;
        rx87  = 1'b1;
        repeat (3) @(negedge clk);
        rst16 = 1'b0;
        rst87 = 1'b0;
        @(negedge clk);

        check_eq("reset_byte", 32'(byte16), 32'h00);
        check_eq("reset_dv", 32'(dv16), 32'd0);
        check_eq("reset_fe", 32'(fe16), 32'd0);
        check_eq("reset_active", 32'(act16), 32'd0);
        check_eq("reset_byte87", 32'(byte87), 32'h00);

        // Clean frame 0xA5.
        fork
            send_frame(0, 16, 8'hA5, 1'b1);
            begin
                repeat (80) @(negedge clk);
                check_eq("a5_active_mid", 32'(act16), 32'd1);
            end
        join
        repeat (4) @(negedge clk);
        check_eq("a5_dv_count", 32'(dv_cyc16.size()), 32'd1);
        if (dv_cyc16.size() > 0) begin
            check_eq("a5_latency", 32'(dv_cyc16[0] - t0), 32'd154);
            check_eq("a5_dv_byte", 32'(dv_byte16[0]), 32'hA5);
        end
        check_eq("a5_byte_hold", 32'(byte16), 32'hA5);
        check_eq("a5_no_fe", 32'(fe_cnt16), 32'd0);
        check_eq("a5_active_end", 32'(act16), 32'd0);

        // Back-to-back 0x00 then 0xFF.
        dv_cyc16.delete();
        dv_byte16.delete();
        send_frame(0, 16, 8'h00, 1'b1);
        t_first = t0;
        send_frame(0, 16, 8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("b2b_dv_count", 32'(dv_cyc16.size()), 32'd2);
        if (dv_cyc16.size() == 2) begin
            check_eq("b2b_latency", 32'(dv_cyc16[0] - t_first), 32'd154);
            check_eq("b2b_spacing", 32'(dv_cyc16[1] - dv_cyc16[0]), 32'd160);
            check_eq("b2b_byte0", 32'(dv_byte16[0]), 32'h00);
            check_eq("b2b_byte1", 32'(dv_byte16[1]), 32'hFF);
        end

        // 5-cycle glitch on idle line.
        dv_cyc16.delete();
        dv_byte16.delete();
        rx16 = 1'b0;
        repeat (5) @(negedge clk);
        rx16 = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_no_dv", 32'(dv_cyc16.size()), 32'd0);
        check_eq("glitch_no_fe", 32'(fe_cnt16), 32'd0);
        check_eq("glitch_active", 32'(act16), 32'd0);
        check_eq("glitch_state", 32'(dut16.state_q), 32'(IDLE));
        check_eq("glitch_byte", 32'(byte16), 32'hFF);

        // Bad stop bit for 0x3C, then the line held low.
        send_frame(0, 16, 8'h3C, 1'b0);
        repeat (400) @(negedge clk);
        check_eq("fe_count", 32'(fe_cnt16), 32'd1);
        check_eq("fe_latency", 32'(fe_cyc16 - t0), 32'd154);
        check_eq("fe_no_dv", 32'(dv_cyc16.size()), 32'd0);
        check_eq("fe_byte_hold", 32'(byte16), 32'hFF);
        check_eq("break_active", 32'(act16), 32'd0);
        check_eq("break_state", 32'(dut16.state_q), 32'(BREAK));
        rx16 = 1'b1;
        repeat (32) @(negedge clk);
        check_eq("break_exit", 32'(dut16.state_q), 32'(IDLE));
        send_frame(0, 16, 8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("post_break_dv", 32'(dv_cyc16.size()), 32'd1);
        check_eq("post_break_byte", 32'(byte16), 32'h81);
        check_eq("post_break_fe", 32'(fe_cnt16), 32'd1);

        // Reset during data bit 4 of 0x5A; transmitter abandons the frame.
        dv_cyc16.delete();
        dv_byte16.delete();
        v = 8'h5A;
        rx16 = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx16 = v[i];
            repeat (16) @(negedge clk);
        end
        rx16 = v[4];
        repeat (8) @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        check_eq("rst_byte", 32'(byte16), 32'h00);
        check_eq("rst_dv", 32'(dv16), 32'd0);
        check_eq("rst_active", 32'(act16), 32'd0);
        check_eq("rst_state", 32'(dut16.state_q), 32'(IDLE));
        rx16 = 1'b1;
        repeat (48) @(negedge clk);
        check_eq("rst_no_dv", 32'(dv_cyc16.size()), 32'd0);
        check_eq("rst_no_fe", 32'(fe_cnt16), 32'd1);
        send_frame(0, 16, 8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("c3_dv_count", 32'(dv_cyc16.size()), 32'd1);
        if (dv_cyc16.size() > 0) begin
            check_eq("c3_latency", 32'(dv_cyc16[0] - t0), 32'd154);
        end
        check_eq("c3_byte", 32'(byte16), 32'hC3);

        // N=87, 0x55.
        send_frame(1, 87, 8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("n87_dv_count", 32'(dv_cyc87.size()), 32'd1);
        if (dv_cyc87.size() > 0) begin
            check_eq("n87_latency", 32'(dv_cyc87[0] - t0), 32'd829);
            check_eq("n87_dv_byte", 32'(dv_byte87[0]), 32'h55);
        end
        check_eq("n87_byte", 32'(byte87), 32'h55);
        check_eq("n87_no_fe", 32'(fe_cnt87), 32'd0);

        check_eq("dv_fe_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
